// File: rtl/bpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// bpsk_symbol_scheduler - BPSK burst framer: warm-up, alternating preamble,
// then FIFO-fed data symbols applied as sign flips on an external carrier.
// Revision: 1.0
// ============================================================================

module bpsk_symbol_scheduler #(
  parameter int CYC_PER_SYM = 4,
  parameter int PRE_LEN     = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk_sig,
  input  logic               reset_sig,
  input  logic               start_sig,
  input  logic               bit_valid,
  input  logic               bit_data,
  output logic               bit_ready,
  input  logic signed [15:0] carrier_sig,
  input  logic               cycle_sig,
  output logic               carrier_en,
  output logic signed [15:0] mod_sig,
  output logic               sym_sig,
  output logic               busy_sig
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0]    c_per_last = 4'(CYC_PER_SYM - 1);
  localparam logic [7:0]    c_pre_last = 8'(PRE_LEN - 1);
  localparam logic [AW-1:0] c_ptr_last = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] c_cnt_full = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_PRE  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         per_q, per_d;
  logic [7:0]         pre_q, pre_d;
  logic               sign_q, sign_d;
  logic signed [15:0] mod_q, mod_d;
  logic               sym_q, sym_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;

  logic               mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;

  logic               w_full, w_empty, w_push, w_pop, w_head;
  logic               w_in_sym, w_per_last, w_boundary, w_data_step;
  logic               w_active_d;
  logic [7:0]         w_pre_inc;
  logic signed [15:0] w_neg;

  assign w_full  = (cnt_q == c_cnt_full);
  assign w_empty = (cnt_q == '0);
  assign w_head  = mem_q[rd_q];
  assign w_push  = bit_valid && !w_full;

  assign w_in_sym    = (state_q == S_PRE) || (state_q == S_DATA);
  assign w_per_last  = (per_q == c_per_last);
  assign w_boundary  = cycle_sig && ((state_q == S_WARM) || (w_in_sym && w_per_last));
  // Boundaries that need a data bit: every DATA boundary plus the one closing the preamble.
  assign w_data_step = w_boundary &&
                       ((state_q == S_DATA) || ((state_q == S_PRE) && (pre_q == c_pre_last)));
  assign w_pop       = w_data_step && !w_empty;
  assign w_pre_inc   = pre_q + 8'd1;

  assign w_neg = (carrier_sig == 16'sh8000) ? 16'sh7FFF : -carrier_sig;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    pre_d   = pre_q;
    sign_d  = sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_sig) state_d = S_WARM;
      end
      S_WARM: begin
        if (cycle_sig) begin
          state_d = S_PRE;
          per_d   = '0;
          pre_d   = '0;
          sign_d  = 1'b0;
        end
      end
      S_PRE, S_DATA: begin
        if (cycle_sig) begin
          if (w_per_last) begin
            per_d = '0;
            if (w_data_step) begin
              if (w_empty) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_DATA;
                sign_d  = w_head;
              end
            end else begin
              pre_d  = w_pre_inc;
              sign_d = w_pre_inc[0];
            end
          end else begin
            per_d = per_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so a boundary's sign hits that cycle's sample.
    w_active_d = (state_d == S_PRE) || (state_d == S_DATA);
    en_d       = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    sym_d      = w_boundary && w_active_d;
    mod_d      = w_active_d ? (sign_d ? w_neg : carrier_sig) : 16'sd0;
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      pre_q   <= '0;
      sign_q  <= 1'b0;
      mod_q   <= '0;
      sym_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      sign_q  <= sign_d;
      mod_q   <= mod_d;
      sym_q   <= sym_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= (wr_q == c_ptr_last) ? '0 : wr_q + AW'(1);
      if (w_pop)  rd_q <= (rd_q == c_ptr_last) ? '0 : rd_q + AW'(1);
      if (w_push && !w_pop)      cnt_q <= cnt_q + CW'(1);
      else if (w_pop && !w_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_sig) begin
    if (w_push) mem_q[wr_q] <= bit_data;
  end

  assign bit_ready  = !w_full;
  assign carrier_en = en_q;
  assign mod_sig    = mod_q;
  assign sym_sig    = sym_q;
  assign busy_sig   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// tb_bpsk_symbol_scheduler - directed + randomized bench with a symbol-level
// reference model (pulse counting, preamble parity, bit queue).
// Revision: 1.0
// ============================================================================

module tb_bpsk_symbol_scheduler;

  localparam int CPS   = 4;
  localparam int PRE   = 8;
  localparam int DEPTH = 4;

  logic               clk_sig = 1'b0;
  logic               reset_sig, start_sig, bit_valid, bit_data, cycle_sig;
  logic               bit_ready, carrier_en, sym_sig, busy_sig;
  logic signed [15:0] carrier_sig, mod_sig;

  int checks = 0;
  int errors = 0;

  always #5 clk_sig = ~clk_sig;

  bpsk_symbol_scheduler #(
    .CYC_PER_SYM (CPS),
    .PRE_LEN     (PRE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_sig     (clk_sig),
    .reset_sig   (reset_sig),
    .start_sig   (start_sig),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .carrier_sig (carrier_sig),
    .cycle_sig   (cycle_sig),
    .carrier_en  (carrier_en),
    .mod_sig     (mod_sig),
    .sym_sig     (sym_sig),
    .busy_sig    (busy_sig)
  );

  // Carrier generator stand-in: held in reset while carrier_en is low.
  int per = 4;
  int ph  = 0;

  // Reference model: 0 idle, 1 warm, 2 sending symbols.
  int                 m_phase;
  int                 m_pulses;
  bit                 m_sign;
  bit                 q[$];
  bit                 e_sym;
  logic signed [15:0] e_mod;
  int                 dut_syms;

  function automatic logic signed [15:0] bpsk(bit s, logic signed [15:0] c);
    if (!s) return c;
    if (c == 16'sh8000) return 16'sh7FFF;
    return -c;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase  = 0;
    m_pulses = 0;
    m_sign   = 1'b0;
    e_sym    = 1'b0;
    e_mod    = 16'sd0;
  endtask

  task automatic model_step();
    bit push_ok;
    int s;
    push_ok = bit_valid && (q.size() < DEPTH);
    e_sym   = 1'b0;
    if (m_phase == 0) begin
      if (start_sig) m_phase = 1;
    end else if (cycle_sig) begin
      if (m_phase == 1) begin
        m_phase  = 2;
        m_pulses = 0;
        m_sign   = 1'b0;
        e_sym    = 1'b1;
      end else begin
        m_pulses++;
        if (m_pulses % CPS == 0) begin
          s = m_pulses / CPS;
          if (s < PRE) begin
            m_sign = ((s % 2) != 0);
            e_sym  = 1'b1;
          end else if (q.size() > 0) begin
            m_sign = q.pop_front();
            e_sym  = 1'b1;
          end else begin
            m_phase = 0;
          end
        end
      end
    end
    if (push_ok) q.push_back(bit_data);
    e_mod = (m_phase == 2) ? bpsk(m_sign, carrier_sig) : 16'sd0;
  endtask

  task automatic check_outs();
    chk("carrier_en", carrier_en, (m_phase != 0));
    chk("busy",       busy_sig,   (m_phase != 0));
    chk("sym",        sym_sig,    e_sym);
    chk("mod",        mod_sig,    e_mod);
    chk("ready",      bit_ready,  (q.size() < DEPTH));
  endtask

  task automatic drive_env();
    if (!carrier_en) begin
      ph        = 0;
      cycle_sig = 1'b0;
    end else begin
      cycle_sig = (ph == 0);
      ph        = (ph + 1) % per;
    end
    carrier_sig = ($urandom_range(0, 15) == 0) ? 16'sh8000 : 16'($urandom);
  endtask

  task automatic cycle();
    @(posedge clk_sig);
    if (reset_sig) model_reset();
    else model_step();
    #1;
    check_outs();
    if (sym_sig) dut_syms++;
    drive_env();
  endtask

  task automatic push_bits(int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'($urandom);
      cycle();
    end
    bit_valid = 1'b0;
  endtask

  task automatic start_frame();
    dut_syms  = 0;
    start_sig = 1'b1;
    cycle();
    start_sig = 1'b0;
  endtask

  task automatic wait_syms(string tag, int n, int budget);
    for (int i = 0; i < budget && dut_syms < n; i++) cycle();
    chk(tag, dut_syms, n);
  endtask

  task automatic run_until_idle(string tag, int budget);
    for (int i = 0; i < budget && m_phase != 0; i++) cycle();
    cycle();
    chk(tag, busy_sig, 0);
  endtask

  initial begin
    reset_sig   = 1'b1;
    start_sig   = 1'b0;
    bit_valid   = 1'b0;
    bit_data    = 1'b0;
    carrier_sig = 16'sd0;
    cycle_sig   = 1'b0;
    dut_syms    = 0;
    model_reset();
    #1;
    check_outs();
    cycle();
    cycle();
    #3 reset_sig = 1'b0;

    // Preloaded 1,0,1 frame with a slow carrier: 8 preamble + 3 data symbols.
    per = 256;
    bit_valid = 1'b1; bit_data = 1'b1; cycle();
    bit_data = 1'b0; cycle();
    bit_data = 1'b1; cycle();
    bit_valid = 1'b0;
    start_frame();
    run_until_idle("frame_037_end", 14000);
    chk("syms_037", dut_syms, 11);
    chk("en_037", carrier_en, 0);

    // Sign and saturation inside preamble symbol 1, then empty-FIFO end of frame.
    per = 2;
    start_frame();
    wait_syms("wait_pre1", 2, 200);
    carrier_sig = 16'sd1000;
    cycle();
    chk("neg_1000", mod_sig, -1000);
    carrier_sig = 16'sh8000;
    cycle();
    chk("sat_neg", mod_sig, 32767);
    run_until_idle("frame_040_end", 500);
    chk("syms_040", dut_syms, PRE);
    chk("en_040", carrier_en, 0);

    // FIFO full in IDLE, held fifth bit refused until the first data pop.
    push_bits(4);
    chk("ready_full", bit_ready, 0);
    bit_valid = 1'b1;
    bit_data  = 1'($urandom);
    cycle(); cycle(); cycle();
    chk("ready_held", bit_ready, 0);
    start_frame();
    wait_syms("wait_data_039", PRE + 1, 500);
    chk("ready_after_pop", bit_ready, 1);
    bit_valid = 1'b0;
    run_until_idle("frame_039_end", 500);
    chk("syms_039", dut_syms, PRE + 4);

    // Push coinciding with a data boundary while two bits are queued.
    per = 2;
    push_bits(3);
    start_frame();
    wait_syms("wait_data_042", PRE + 1, 500);
    for (int i = 0; i < 100; i++) begin
      if (m_phase == 2 && cycle_sig && ((m_pulses + 1) % CPS == 0)) break;
      cycle();
    end
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    cycle();
    bit_valid = 1'b0;
    run_until_idle("frame_042_end", 500);
    chk("syms_042", dut_syms, PRE + 4);

    // Asynchronous reset mid-DATA, then no activity until a new start.
    push_bits(2);
    start_frame();
    wait_syms("wait_data_041", PRE + 1, 500);
    #3 reset_sig = 1'b1;
    #1;
    model_reset();
    check_outs();
    cycle();
    cycle();
    #3 reset_sig = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    chk("stay_idle", busy_sig, 0);
    start_frame();
    run_until_idle("frame_041_end", 500);
    chk("syms_041", dut_syms, PRE);

    // Randomized frames: random carrier rate, preload, pushes and stray starts.
    for (int f = 0; f < 4; f++) begin
      per = $urandom_range(1, 5);
      push_bits($urandom_range(0, DEPTH));
      start_frame();
      for (int i = 0; i < 60; i++) begin
        bit_valid = ($urandom_range(0, 3) == 0);
        bit_data  = 1'($urandom);
        start_sig = ($urandom_range(0, 7) == 0) && (m_phase != 0);
        cycle();
      end
      bit_valid = 1'b0;
      start_sig = 1'b0;
      run_until_idle("frame_rand_end", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
